qar_i2c_xfer_sched: RTL and testbench
=====================================

Name: qar_i2c_xfer_sched

Overview:
- Shares the QAR-Core I2C byte engine between NREQ requesters, e.g. the core MMIO path and a hardware sensor poller.
- Each requester posts a single-register transaction: write one byte, or read one byte.
- The scheduler arbitrates round-robin and expands the granted transaction into the engine command sequence (START/WRITE/READ/STOP).
- It handles NACK abort and returns read data plus status to the owning requester.

Parameters:
- NREQ, 2, number of requesters (2..4).
- RR_INIT, 0, requester index holding top priority after reset.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  transaction request per requester
- req_ready  out  NREQ  one-hot accept pulse
- req_rw  in  NREQ  0 = write, 1 = read
- req_dev  in  7*NREQ  7-bit device address, requester i at [7i+6:7i]
- req_reg  in  8*NREQ  register pointer
- req_wdata  in  8*NREQ  write byte (ignored on read)
- done_valid  out  NREQ  one-hot completion pulse
- done_rdata  out  8  read byte, valid with done_valid
- done_err  out  1  1 = NACK abort, valid with done_valid
- busy  out  1  transaction in flight
- cmd_valid  out  1  command to byte engine
- cmd_ready  in  1  engine accepts command
- cmd_op  out  3  0 START, 1 RSTART, 2 WRITE, 3 READ_NACK, 4 STOP
- cmd_data  out  8  byte for WRITE
- rsp_valid  in  1  engine finished the accepted command
- rsp_nack  in  1  slave NACKed (WRITE only)
- rsp_data  in  8  received byte (READ_NACK only)

Behaviour:
- Reset values: all outputs 0; state IDLE; rr pointer = RR_INIT; latched transaction cleared.
- Arbitration, IDLE state:
  - If any req_valid, grant the first set bit at or after the rr pointer, wrapping modulo NREQ.
  - Assert req_ready[g] for exactly one cycle; latch rw/dev/reg/wdata; owner = g; set rr = (g+1) mod NREQ; busy = 1.
  - A request is latched 1 cycle after req_valid is seen.
  - Non-granted requests stay pending; requesters hold valid and fields stable until ready.
- Command handshake:
  - Each command state drives cmd_valid = 1 with op/data until cmd_ready; the command transfers on cmd_valid & cmd_ready.
  - The FSM then waits in the matching WAIT phase for rsp_valid.
  - Only one command is outstanding at a time.
  - rsp_valid arriving without an outstanding command is ignored.
- Sequence, write transaction: START, WRITE {dev,0}, WRITE reg, WRITE wdata, STOP.
- Sequence, read transaction: START, WRITE {dev,0}, WRITE reg, RSTART, WRITE {dev,1}, READ_NACK, STOP.
- States: IDLE, START, DEVW, REG, WDAT, RSTART, DEVR, RDAT, STOP, DONE, each command state with its wait phase.
- NACK handling:
  - On rsp_nack for any WRITE, set err = 1 and jump to STOP; remaining commands are skipped.
  - STOP is always issued before DONE.
- RDAT: capture rsp_data into done_rdata register on rsp_valid.
- DONE, one cycle:
  - done_valid[owner] = 1; done_err = err; done_rdata held until the next DONE.
  - Clear busy and err; return to IDLE.
  - The next grant can occur in the cycle after DONE.
- cmd_data is 0 for non-WRITE ops. rsp_nack is ignored on non-WRITE ops.
- Simultaneous events:
  - A requester's valid asserted during its own DONE cycle is treated as a new request.
  - A requester dropping req_valid before its grant simply loses arbitration.
- Reset mid-transaction: immediate return to IDLE with all outputs 0. No STOP is issued; the engine is reset by the same rst.
- Minimum write transaction, zero-latency engine: 1 grant + 5 × 2 + 1 done = 12 cycles.

Decomposition:
- Shared package qar_i2c_pkg:
  - cmd_op encodings (I2C_CMD_START..I2C_CMD_STOP)
  - FSM state enum
  - I2C_ADDR_W = 7
- Sub-module qar_rr_arbiter (NREQ-wide round-robin grant with pointer update on accept); reusable for other shared peripherals.

Test Plan:
- Write, req0 dev=0x50 reg=0x10 wdata=0xA5, engine always ACKs -> cmd sequence START, WRITE 0xA0, WRITE 0x10, WRITE 0xA5, STOP; done_valid=2'b01, done_err=0.
- Read, req1 dev=0x50 reg=0x20, engine returns 0x64 -> START, WRITE 0xA0, WRITE 0x20, RSTART, WRITE 0xA1, READ_NACK, STOP; done_valid=2'b10, done_rdata=0x64, done_err=0.
- NACK on address, req0 dev=0x3C with rsp_nack=1 on the first WRITE -> next command is STOP, no further WRITEs; done_err=1.
- Contention, req0 and req1 valid together from reset -> order 0, 1, 0, 1 across four back-to-back transactions; req_ready is one-hot each time.
- Backpressure, cmd_ready low for 5 cycles per command -> cmd_valid/op/data held stable; transaction completes with correct sequence.
- rst pulsed during RDAT wait -> all outputs 0 within the reset cycle; a fresh write then completes normally with done_err=0.

Source files
------------

// File: rtl/qar_i2c_pkg.sv
// Shared definitions for the QAR-Core I2C transfer scheduler: engine opcodes,
// address width and scheduler FSM states.
package qar_i2c_pkg;

  localparam int I2C_ADDR_W = 7;

  localparam logic [2:0] I2C_CMD_START     = 3'd0;
  localparam logic [2:0] I2C_CMD_RSTART    = 3'd1;
  localparam logic [2:0] I2C_CMD_WRITE     = 3'd2;
  localparam logic [2:0] I2C_CMD_READ_NACK = 3'd3;
  localparam logic [2:0] I2C_CMD_STOP      = 3'd4;

  // Every command state is followed by its wait phase (_W).
  typedef enum logic [4:0] {
    ST_IDLE,
    ST_START,  ST_START_W,
    ST_DEVW,   ST_DEVW_W,
    ST_REG,    ST_REG_W,
    ST_WDAT,   ST_WDAT_W,
    ST_RSTART, ST_RSTART_W,
    ST_DEVR,   ST_DEVR_W,
    ST_RDAT,   ST_RDAT_W,
    ST_STOP,   ST_STOP_W,
    ST_DONE
  } xfer_state_t;

endpackage

// File: rtl/qar_rr_arbiter.sv
// NREQ-wide round-robin arbiter; the priority pointer moves past the winner
// only when the grant is accepted.
module qar_rr_arbiter
  import qar_i2c_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RR_INIT = 0
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic                    accept,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_idx
);

  localparam int IW = $clog2(NREQ);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW:0]   cand;
  logic          found;

  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      cand = {1'b0, ptr_q} + (IW+1)'(k);
      if (cand >= (IW+1)'(NREQ)) cand = cand - (IW+1)'(NREQ);
      if (!found && req[cand[IW-1:0]]) begin
        found     = 1'b1;
        grant_idx = cand[IW-1:0];
      end
    end
    grant = found ? ({{(NREQ-1){1'b0}}, 1'b1} << grant_idx) : '0;
    ptr_d = ptr_q;
    if (accept && found)
      ptr_d = (grant_idx == IW'(NREQ-1)) ? '0 : grant_idx + IW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= IW'(RR_INIT);
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/qar_i2c_xfer_sched.sv
// Shares one I2C byte engine between NREQ requesters: round-robin grant, then
// expansion of a one-register read/write into START/WRITE/READ/STOP commands.
module qar_i2c_xfer_sched
  import qar_i2c_pkg::*;
#(
  parameter int NREQ    = 2,
  parameter int RR_INIT = 0
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NREQ-1:0]            req_valid,
  output logic [NREQ-1:0]            req_ready,
  input  logic [NREQ-1:0]            req_rw,
  input  logic [I2C_ADDR_W*NREQ-1:0] req_dev,
  input  logic [8*NREQ-1:0]          req_reg,
  input  logic [8*NREQ-1:0]          req_wdata,
  output logic [NREQ-1:0]            done_valid,
  output logic [7:0]                 done_rdata,
  output logic                       done_err,
  output logic                       busy,
  output logic                       cmd_valid,
  input  logic                       cmd_ready,
  output logic [2:0]                 cmd_op,
  output logic [7:0]                 cmd_data,
  input  logic                       rsp_valid,
  input  logic                       rsp_nack,
  input  logic [7:0]                 rsp_data
);

  localparam int IW = $clog2(NREQ);

  xfer_state_t           state_q, state_d;
  logic [NREQ-1:0]       grant;
  logic [IW-1:0]         grant_idx;
  logic                  accept;
  logic [IW-1:0]         owner_q, owner_d;
  logic                  rw_q, rw_d, err_q, err_d;
  logic [I2C_ADDR_W-1:0] dev_q, dev_d, dev_sel;
  logic [7:0]            reg_q, reg_d, reg_sel;
  logic [7:0]            wdata_q, wdata_d, wdata_sel;
  logic [7:0]            rcap_q, rcap_d, hold_q, hold_d;
  logic                  rw_sel;

  assign accept    = (state_q == ST_IDLE) && (|req_valid) && !rst;
  assign req_ready = accept ? grant : '0;
  assign busy      = (state_q != ST_IDLE);

  qar_rr_arbiter #(.NREQ(NREQ), .RR_INIT(RR_INIT)) u_arb (
    .clk       (clk),
    .rst       (rst),
    .req       (req_valid),
    .accept    (accept),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  always_comb begin
    rw_sel    = 1'b0;
    dev_sel   = '0;
    reg_sel   = '0;
    wdata_sel = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_idx == IW'(k)) begin
        rw_sel    = req_rw[k];
        dev_sel   = req_dev[k*I2C_ADDR_W +: I2C_ADDR_W];
        reg_sel   = req_reg[k*8 +: 8];
        wdata_sel = req_wdata[k*8 +: 8];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    rw_d       = rw_q;
    dev_d      = dev_q;
    reg_d      = reg_q;
    wdata_d    = wdata_q;
    err_d      = err_q;
    rcap_d     = rcap_q;
    hold_d     = hold_q;
    cmd_valid  = 1'b0;
    cmd_op     = '0;
    cmd_data   = '0;
    done_valid = '0;
    done_err   = 1'b0;
    done_rdata = hold_q;
    unique case (state_q)
      ST_IDLE: if (accept) begin
        owner_d = grant_idx;
        rw_d    = rw_sel;
        dev_d   = dev_sel;
        reg_d   = reg_sel;
        wdata_d = wdata_sel;
        err_d   = 1'b0;
        state_d = ST_START;
      end
      ST_START: begin
        cmd_valid = 1'b1;
        cmd_op    = I2C_CMD_START;
        if (cmd_ready) state_d = ST_START_W;
      end
      ST_START_W: if (rsp_valid) state_d = ST_DEVW;
      ST_DEVW: begin
        cmd_valid = 1'b1;
        cmd_op    = I2C_CMD_WRITE;
        cmd_data  = {dev_q, 1'b0};
        if (cmd_ready) state_d = ST_DEVW_W;
      end
      ST_DEVW_W: if (rsp_valid) begin
        err_d   = err_q | rsp_nack;
        state_d = rsp_nack ? ST_STOP : ST_REG;
      end
      ST_REG: begin
        cmd_valid = 1'b1;
        cmd_op    = I2C_CMD_WRITE;
        cmd_data  = reg_q;
        if (cmd_ready) state_d = ST_REG_W;
      end
      ST_REG_W: if (rsp_valid) begin
        err_d   = err_q | rsp_nack;
        state_d = rsp_nack ? ST_STOP : (rw_q ? ST_RSTART : ST_WDAT);
      end
      ST_WDAT: begin
        cmd_valid = 1'b1;
        cmd_op    = I2C_CMD_WRITE;
        cmd_data  = wdata_q;
        if (cmd_ready) state_d = ST_WDAT_W;
      end
      ST_WDAT_W: if (rsp_valid) begin
        err_d   = err_q | rsp_nack;
        state_d = ST_STOP;
      end
      ST_RSTART: begin
        cmd_valid = 1'b1;
        cmd_op    = I2C_CMD_RSTART;
        if (cmd_ready) state_d = ST_RSTART_W;
      end
      ST_RSTART_W: if (rsp_valid) state_d = ST_DEVR;
      ST_DEVR: begin
        cmd_valid = 1'b1;
        cmd_op    = I2C_CMD_WRITE;
        cmd_data  = {dev_q, 1'b1};
        if (cmd_ready) state_d = ST_DEVR_W;
      end
      ST_DEVR_W: if (rsp_valid) begin
        err_d   = err_q | rsp_nack;
        state_d = rsp_nack ? ST_STOP : ST_RDAT;
      end
      ST_RDAT: begin
        cmd_valid = 1'b1;
        cmd_op    = I2C_CMD_READ_NACK;
        if (cmd_ready) state_d = ST_RDAT_W;
      end
      ST_RDAT_W: if (rsp_valid) begin
        rcap_d  = rsp_data;
        state_d = ST_STOP;
      end
      ST_STOP: begin
        cmd_valid = 1'b1;
        cmd_op    = I2C_CMD_STOP;
        if (cmd_ready) state_d = ST_STOP_W;
      end
      ST_STOP_W: if (rsp_valid) state_d = ST_DONE;
      ST_DONE: begin
        // The read byte shows in DONE and is then held until the next DONE.
        done_valid = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
        done_err   = err_q;
        done_rdata = rcap_q;
        hold_d     = rcap_q;
        err_d      = 1'b0;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      owner_q <= '0;
      rw_q    <= 1'b0;
      dev_q   <= '0;
      reg_q   <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rcap_q  <= '0;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rw_q    <= rw_d;
      dev_q   <= dev_d;
      reg_q   <= reg_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rcap_q  <= rcap_d;
      hold_q  <= hold_d;
    end
  end

endmodule

// File: tb/tb_qar_i2c_xfer_sched.sv
// Bench for qar_i2c_xfer_sched: requesters and byte engine are modelled here,
// and a transaction-level reference predicts grants, command streams and completions.
module tb_qar_i2c_xfer_sched;

  localparam int N = 2;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0, req_ready, req_rw = '0, done_valid;
  logic [7*N-1:0] req_dev = '0;
  logic [8*N-1:0] req_reg = '0, req_wdata = '0;
  logic [7:0]     done_rdata, cmd_data, rsp_data = '0;
  logic           done_err, busy, cmd_valid, cmd_ready = 1'b0;
  logic [2:0]     cmd_op;
  logic           rsp_valid = 1'b0, rsp_nack = 1'b0;

  always #5 clk = ~clk;

  qar_i2c_xfer_sched #(.NREQ(N), .RR_INIT(0)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw),
    .req_dev(req_dev), .req_reg(req_reg), .req_wdata(req_wdata),
    .done_valid(done_valid), .done_rdata(done_rdata), .done_err(done_err),
    .busy(busy), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_nack(rsp_nack), .rsp_data(rsp_data)
  );

  int vectors = 0, miscompares = 0;

  // requester side
  bit       pend [N];
  bit       p_rw [N];
  bit [6:0] p_dev[N];
  bit [7:0] p_reg[N], p_wd[N];
  bit       gen_en = 0;

  // engine side
  int       rdy_mode = 0;   // 0 always ready, 1 random, 2 five-cycle stall per command
  int       stall_cnt = 0, lat = 0, lat_max = 0, nack_pct = 0;
  bit       fix_rdata_en = 0;
  bit [7:0] fix_rdata = 0;

  // reference model
  int        rr = 0, owner = 0, done_cnt = 0;
  bit        m_busy = 0, m_rw = 0, m_err = 0, outst = 0;
  bit [2:0]  out_op = 0;
  bit [7:0]  m_rdata = 0;
  bit [10:0] expq[$];
  bit [10:0] cmdlog[$];
  int        gnt_log[$];
  bit [N-1:0] last_done_valid;
  bit        last_err;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic post(input int i, input bit rw, input bit [6:0] dev, input bit [7:0] rg, input bit [7:0] wd);
    pend[i] = 1; p_rw[i] = rw; p_dev[i] = dev; p_reg[i] = rg; p_wd[i] = wd;
  endtask

  task automatic start_xfer(input int g);
    owner = g; m_rw = p_rw[g]; m_err = 0; pend[g] = 0;
    rr = (g + 1) % N;
    gnt_log.push_back(g);
    expq.delete();
    expq.push_back({3'd0, 8'h00});
    expq.push_back({3'd2, p_dev[g], 1'b0});
    expq.push_back({3'd2, p_reg[g]});
    if (!p_rw[g]) expq.push_back({3'd2, p_wd[g]});
    else begin
      expq.push_back({3'd1, 8'h00});
      expq.push_back({3'd2, p_dev[g], 1'b1});
      expq.push_back({3'd3, 8'h00});
    end
    expq.push_back({3'd4, 8'h00});
    m_busy = 1;
  endtask

  task automatic step();
    int g;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (!pend[i] && gen_en && $urandom_range(0, 3) == 0)
        post(i, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
      req_valid[i]         = pend[i];
      req_rw[i]            = pend[i] ? p_rw[i] : 1'($urandom);
      req_dev[i*7 +: 7]    = pend[i] ? p_dev[i] : 7'($urandom);
      req_reg[i*8 +: 8]    = pend[i] ? p_reg[i] : 8'($urandom);
      req_wdata[i*8 +: 8]  = pend[i] ? p_wd[i] : 8'($urandom);
    end
    case (rdy_mode)
      0: cmd_ready = 1'b1;
      1: cmd_ready = 1'($urandom);
      default: begin
        cmd_ready = (stall_cnt >= 5);
        if (m_busy && !outst && expq.size() > 0 && stall_cnt < 5) stall_cnt++;
      end
    endcase
    rsp_valid = 1'b0; rsp_nack = 1'($urandom); rsp_data = 8'($urandom);
    if (outst) begin
      if (lat == 0) begin
        rsp_valid = 1'b1;
        if (out_op == 3'd2) rsp_nack = ($urandom_range(0, 99) < nack_pct);
        if (out_op == 3'd3 && fix_rdata_en) rsp_data = fix_rdata;
      end else lat--;
    end else rsp_valid = ($urandom_range(0, 7) == 0);

    @(negedge clk);
    if (!m_busy) begin
      chk("idle_busy", busy, 0);
      chk("idle_cmd_valid", cmd_valid, 0);
      chk("idle_done_valid", done_valid, 0);
      g = -1;
      for (int k = 0; k < N; k++)
        if (g < 0 && pend[(rr + k) % N]) g = (rr + k) % N;
      if (g >= 0) begin
        chk("grant_req_ready", req_ready, 1 << g);
        start_xfer(g);
      end else chk("idle_req_ready", req_ready, 0);
    end else begin
      chk("busy", busy, 1);
      chk("busy_req_ready", req_ready, 0);
      if (outst) begin
        chk("wait_cmd_valid", cmd_valid, 0);
        chk("wait_done_valid", done_valid, 0);
        if (rsp_valid) begin
          outst = 0;
          if (out_op == 3'd2 && rsp_nack) begin
            m_err = 1;
            expq.delete();
            expq.push_back({3'd4, 8'h00});
          end
          if (out_op == 3'd3) m_rdata = rsp_data;
        end
      end else if (expq.size() > 0) begin
        chk("cmd_valid", cmd_valid, 1);
        chk("cmd_op_data", {cmd_op, cmd_data}, expq[0]);
        chk("cmd_done_valid", done_valid, 0);
        if (cmd_ready) begin
          cmdlog.push_back({cmd_op, cmd_data});
          out_op = expq[0][10:8];
          void'(expq.pop_front());
          outst = 1;
          lat = $urandom_range(0, lat_max);
          stall_cnt = 0;
        end
      end else begin
        chk("done_valid", done_valid, 1 << owner);
        chk("done_err", done_err, m_err);
        chk("done_cmd_valid", cmd_valid, 0);
        if (m_rw) chk("done_rdata", done_rdata, m_rdata);
        last_done_valid = done_valid;
        last_err = done_err;
        done_cnt++;
        m_busy = 0;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req_valid = '0; cmd_ready = 1'b0;
    rsp_valid = 1'b0; rsp_nack = 1'b0; rsp_data = '0;
    for (int i = 0; i < N; i++) pend[i] = 0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cmd_op_data", {cmd_op, cmd_data}, 0);
    chk("rst_done", {done_valid, done_err, done_rdata}, 0);
    rr = 0; m_busy = 0; outst = 0; m_err = 0; stall_cnt = 0;
    expq.delete(); cmdlog.delete(); gnt_log.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic run_until_done(input int maxc, output int cyc);
    int start;
    start = done_cnt;
    cyc = 0;
    while (done_cnt == start && cyc < maxc) begin
      step();
      cyc++;
    end
    chk("done_within_bound", done_cnt - start, 1);
  endtask

  task automatic cmp_log(input string nm, input bit [10:0] e[$]);
    chk({nm, "_len"}, cmdlog.size(), e.size());
    for (int i = 0; i < e.size() && i < cmdlog.size(); i++)
      chk($sformatf("%s_cmd%0d", nm, i), cmdlog[i], e[i]);
    cmdlog.delete();
  endtask

  initial begin
    int cyc, start;
    do_reset();

    // minimum write, zero-latency engine
    post(0, 0, 7'h50, 8'h10, 8'hA5);
    run_until_done(100, cyc);
    chk("write_cycles", cyc, 12);
    cmp_log("write", {11'h000, 11'h2A0, 11'h210, 11'h2A5, 11'h400});
    chk("write_done_valid", last_done_valid, 2'b01);
    chk("write_done_err", last_err, 0);

    // read from requester 1
    fix_rdata_en = 1; fix_rdata = 8'h64;
    post(1, 1, 7'h50, 8'h20, 8'h00);
    run_until_done(100, cyc);
    cmp_log("read", {11'h000, 11'h2A0, 11'h220, 11'h100, 11'h2A1, 11'h300, 11'h400});
    chk("read_done_valid", last_done_valid, 2'b10);
    chk("read_rdata_hold", done_rdata, 8'h64);
    fix_rdata_en = 0;

    // address NACK
    nack_pct = 100;
    post(0, 0, 7'h3C, 8'h11, 8'h22);
    run_until_done(100, cyc);
    cmp_log("nack", {11'h000, 11'h278, 11'h400});
    chk("nack_done_err", last_err, 1);
    nack_pct = 0;

    // contention from reset
    do_reset();
    post(0, 0, 7'h11, 8'h01, 8'h02);
    post(1, 1, 7'h22, 8'h03, 8'h00);
    for (int t = 0; t < 4; t++) begin
      run_until_done(100, cyc);
      chk("contention_owner", last_done_valid, 1 << (t % 2));
      if (t < 2) post(t % 2, 1'($urandom), 7'($urandom), 8'($urandom), 8'($urandom));
    end
    chk("contention_grants", gnt_log.size(), 4);
    cmdlog.delete();

    // backpressure
    rdy_mode = 2; lat_max = 2;
    post(1, 0, 7'h2B, 8'h44, 8'h5A);
    run_until_done(400, cyc);
    cmp_log("bp", {11'h000, 11'h256, 11'h244, 11'h25A, 11'h400});
    rdy_mode = 0; lat_max = 0;

    // reset during the read-data wait
    post(0, 1, 7'h50, 8'h30, 8'h00);
    cyc = 0;
    while (!(outst && out_op == 3'd3) && cyc < 100) begin step(); cyc++; end
    chk("rdat_wait_reached", outst && out_op == 3'd3, 1);
    do_reset();
    post(1, 0, 7'h50, 8'h31, 8'h77);
    run_until_done(100, cyc);
    cmp_log("post_rst", {11'h000, 11'h2A0, 11'h231, 11'h277, 11'h400});
    chk("post_rst_err", last_err, 0);
    chk("post_rst_done_valid", last_done_valid, 2'b10);

    // randomized traffic
    do_reset();
    gen_en = 1; rdy_mode = 1; lat_max = 3; nack_pct = 20;
    start = done_cnt;
    repeat (3000) step();
    gen_en = 0;
    cyc = 0;
    while ((m_busy || pend[0] || pend[1]) && cyc < 1000) begin step(); cyc++; end
    chk("drain_idle", m_busy || pend[0] || pend[1], 0);
    chk("random_progress", (done_cnt - start) > 50, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
